// File: rtl/ysyx_rd_arb.sv
`default_nettype none
// ============================================================================
// ysyx_rd_arb : shares one AXI4 read port between IFU bursts and LSU loads,
//               one transaction in flight, with stale-burst draining on flush.
// Revision    : 1.0
// ============================================================================
module ysyx_rd_arb #(
  parameter int         XLEN       = 32,
  parameter logic [3:0] IFU_ID     = 4'h0,
  parameter logic [3:0] LSU_ID     = 4'h1,
  parameter int         STARVE_MAX = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_pipeline,
  input  logic            ifu_arvalid,
  input  logic [XLEN-1:0] ifu_araddr,
  input  logic [7:0]      ifu_arlen,
  input  logic            ifu_lock,
  output logic            out_ifu_arready,
  output logic [XLEN-1:0] out_ifu_rdata,
  output logic            out_ifu_rvalid,
  output logic            out_ifu_rlast,
  input  logic            lsu_arvalid,
  input  logic [XLEN-1:0] lsu_araddr,
  input  logic [7:0]      lsu_rstrb,
  output logic            out_lsu_arready,
  output logic [XLEN-1:0] out_lsu_rdata,
  output logic            out_lsu_rvalid,
  output logic            out_arvalid,
  output logic [XLEN-1:0] out_araddr,
  output logic [7:0]      out_arlen,
  output logic [2:0]      out_arsize,
  output logic [1:0]      out_arburst,
  output logic [3:0]      out_arid,
  input  logic            arready,
  input  logic            rvalid,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  output logic            out_rready,
  output logic            out_rd_err
);

  localparam int                  STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                owner_ifu_q, owner_ifu_d;
  logic                drop_q, drop_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [XLEN-1:0]     araddr_q, araddr_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [2:0]          arsize_q, arsize_d;
  logic [1:0]          arburst_q, arburst_d;
  logic [3:0]          arid_q, arid_d;

  logic       grant_ifu;
  logic       grant_lsu;
  logic       flush_ifu;
  logic [2:0] lsu_size;

  // Grant is combinational in IDLE; held off during reset so no accept pulse escapes.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (ifu_arvalid && (ifu_lock || starve_q == STARVE_LIM)) begin
        grant_ifu = 1'b1;
      end else if (lsu_arvalid) begin
        grant_lsu = 1'b1;
      end else if (ifu_arvalid) begin
        grant_ifu = 1'b1;
      end
    end
  end

  always_comb begin
    case (lsu_rstrb)
      8'h01:   lsu_size = 3'd0;
      8'h03:   lsu_size = 3'd1;
      8'h0f:   lsu_size = 3'd2;
      8'hff:   lsu_size = 3'd3;
      default: lsu_size = 3'd2;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_ifu || grant_lsu) state_d = ADDR;
      ADDR:    if (arready) state_d = DATA;
      DATA:    if (rvalid && rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign flush_ifu = flush_pipeline && owner_ifu_q && (state_q == ADDR || state_q == DATA);

  always_comb begin
    owner_ifu_d = owner_ifu_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    arid_d      = arid_q;
    starve_d    = starve_q;
    if (grant_ifu) begin
      owner_ifu_d = 1'b1;
      araddr_d    = ifu_araddr;
      arlen_d     = ifu_arlen;
      arsize_d    = 3'd2;
      arburst_d   = 2'b01;
      arid_d      = IFU_ID;
      starve_d    = '0;
    end else if (grant_lsu) begin
      owner_ifu_d = 1'b0;
      araddr_d    = lsu_araddr;
      arlen_d     = 8'd0;
      arsize_d    = lsu_size;
      arburst_d   = 2'b01;
      arid_d      = LSU_ID;
      if (ifu_arvalid && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
    end
    // A stale burst keeps draining until rlast; the flag dies with the transaction.
    drop_d = (state_d == IDLE) ? 1'b0 : (drop_q || flush_ifu);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_ifu_q <= 1'b0;
      drop_q      <= 1'b0;
      starve_q    <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      arid_q      <= '0;
    end else begin
      owner_ifu_q <= owner_ifu_d;
      drop_q      <= drop_d;
      starve_q    <= starve_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
      arid_q      <= arid_d;
    end
  end

  always_comb begin
    out_ifu_arready = grant_ifu;
    out_lsu_arready = grant_lsu;
    out_arvalid     = (state_q == ADDR);
    out_rready      = (state_q == DATA);
    out_ifu_rvalid  = rvalid && (state_q == DATA) && owner_ifu_q && !(drop_q || flush_ifu);
    out_lsu_rvalid  = rvalid && (state_q == DATA) && !owner_ifu_q;
    out_rd_err      = (out_ifu_rvalid || out_lsu_rvalid) && (rresp != 2'b00);
  end

  assign out_ifu_rdata = rdata;
  assign out_lsu_rdata = rdata;
  assign out_ifu_rlast = rlast;
  assign out_araddr    = araddr_q;
  assign out_arlen     = arlen_q;
  assign out_arsize    = arsize_q;
  assign out_arburst   = arburst_q;
  assign out_arid      = arid_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_rd_arb.sv
`default_nettype none
// tb_ysyx_rd_arb : transaction-level model of grant rules and beat routing,
// driving both requesters and acting as the AXI slave.
module tb_ysyx_rd_arb;

  localparam int STARVE = 4;

  logic        clock = 1'b0, reset = 1'b1, flush_pipeline = 1'b0;
  logic        ifu_arvalid = 1'b0, ifu_lock = 1'b0;
  logic [31:0] ifu_araddr = '0;
  logic [7:0]  ifu_arlen = '0;
  logic        lsu_arvalid = 1'b0;
  logic [31:0] lsu_araddr = '0;
  logic [7:0]  lsu_rstrb = '0;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;

  wire         out_ifu_arready, out_ifu_rvalid, out_ifu_rlast;
  wire  [31:0] out_ifu_rdata, out_lsu_rdata, out_araddr;
  wire         out_lsu_arready, out_lsu_rvalid, out_arvalid, out_rready, out_rd_err;
  wire  [7:0]  out_arlen;
  wire  [2:0]  out_arsize;
  wire  [1:0]  out_arburst;
  wire  [3:0]  out_arid;

  ysyx_rd_arb dut (
    .clock(clock), .reset(reset), .flush_pipeline(flush_pipeline),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
    .ifu_lock(ifu_lock), .out_ifu_arready(out_ifu_arready),
    .out_ifu_rdata(out_ifu_rdata), .out_ifu_rvalid(out_ifu_rvalid),
    .out_ifu_rlast(out_ifu_rlast), .lsu_arvalid(lsu_arvalid),
    .lsu_araddr(lsu_araddr), .lsu_rstrb(lsu_rstrb),
    .out_lsu_arready(out_lsu_arready), .out_lsu_rdata(out_lsu_rdata),
    .out_lsu_rvalid(out_lsu_rvalid), .out_arvalid(out_arvalid),
    .out_araddr(out_araddr), .out_arlen(out_arlen), .out_arsize(out_arsize),
    .out_arburst(out_arburst), .out_arid(out_arid), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .out_rready(out_rready), .out_rd_err(out_rd_err)
  );

  always #5 clock = ~clock;

  int   vectors = 0;
  int   miscompares = 0;
  int   starve_m = 0;
  logic obs_win_ifu = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Priority list: locked IFU, starved IFU, LSU, plain IFU.
  function automatic logic pick_ifu(input logic iv, input logic lk, input logic lv, input int st);
    if (iv && lk) return 1'b1;
    if (iv && st == STARVE) return 1'b1;
    if (lv) return 1'b0;
    return iv;
  endfunction

  function automatic logic [2:0] size_of(input logic [7:0] s);
    case (s)
      8'h01:   return 3'd0;
      8'h03:   return 3'd1;
      8'h0f:   return 3'd2;
      8'hff:   return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One whole transaction starting in IDLE; requesters already waiting keep their fields.
  task automatic do_txn(input logic iv, input logic lk, input logic [31:0] ia,
                        input logic [7:0] ilen, input logic lv, input logic [31:0] la,
                        input logic [7:0] strb, input int ar_dly, input int flush_at,
                        input int err_at, input logic [31:0] dbase);
    logic        win;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
    logic [2:0]  e_size;
    logic [3:0]  e_id;
    logic        dropped;
    logic        fwd;
    int          nb;
    if (!ifu_arvalid) begin
      ifu_araddr = ia; ifu_arlen = ilen; ifu_lock = lk;
    end
    if (!lsu_arvalid) begin
      lsu_araddr = la; lsu_rstrb = strb;
    end
    ifu_arvalid = iv;
    lsu_arvalid = lv;
    #2;
    chk("idle_arvalid", 64'(out_arvalid), 64'd0);
    chk("idle_rready", 64'(out_rready), 64'd0);
    win = pick_ifu(ifu_arvalid, ifu_lock, lsu_arvalid, starve_m);
    obs_win_ifu = out_ifu_arready;
    chk("ifu_arready", 64'(out_ifu_arready), 64'(win));
    chk("lsu_arready", 64'(out_lsu_arready), 64'(!win));
    if (win) starve_m = 0;
    else if (ifu_arvalid && starve_m < STARVE) starve_m++;
    if (win) begin
      e_addr = ifu_araddr; e_len = ifu_arlen; e_size = 3'd2; e_id = 4'h0;
    end else begin
      e_addr = lsu_araddr; e_len = 8'd0; e_size = size_of(lsu_rstrb); e_id = 4'h1;
    end
    tick();
    if (win) ifu_arvalid = 1'b0;
    else lsu_arvalid = 1'b0;
    for (int c = 0; c <= ar_dly; c++) begin
      arready = (c == ar_dly);
      #2;
      chk("arvalid", 64'(out_arvalid), 64'd1);
      chk("araddr", 64'(out_araddr), 64'(e_addr));
      chk("arlen", 64'(out_arlen), 64'(e_len));
      chk("arsize", 64'(out_arsize), 64'(e_size));
      chk("arburst", 64'(out_arburst), 64'd1);
      chk("arid", 64'(out_arid), 64'(e_id));
      chk("no_accept_in_addr", 64'({out_ifu_arready, out_lsu_arready}), 64'd0);
      tick();
    end
    arready = 1'b0;
    nb = win ? int'(e_len) + 1 : 1;
    dropped = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        rvalid = 1'b0;
        #2;
        chk("gap_rready", 64'(out_rready), 64'd1);
        chk("gap_rvalid", 64'({out_ifu_rvalid, out_lsu_rvalid}), 64'd0);
        tick();
      end
      rvalid = 1'b1;
      rdata = dbase + 32'(b);
      rlast = (b == nb - 1);
      rresp = (b == err_at) ? 2'b10 : 2'b00;
      flush_pipeline = (b == flush_at);
      #2;
      fwd = !(win && (dropped || flush_pipeline));
      chk("beat_rready", 64'(out_rready), 64'd1);
      chk("ifu_rvalid", 64'(out_ifu_rvalid), 64'(win && fwd));
      chk("lsu_rvalid", 64'(out_lsu_rvalid), 64'(!win));
      if (fwd) chk("rdata", 64'(win ? out_ifu_rdata : out_lsu_rdata), 64'(rdata));
      if (win && fwd) chk("ifu_rlast", 64'(out_ifu_rlast), 64'(b == nb - 1));
      chk("rd_err", 64'(out_rd_err), 64'(fwd && b == err_at));
      if (win && flush_pipeline) dropped = 1'b1;
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; flush_pipeline = 1'b0;
  endtask

  logic [4:0] order;
  logic [7:0] strbs [5] = '{8'h01, 8'h03, 8'h0f, 8'hff, 8'h55};

  initial begin
    // Requests present during reset must not be accepted.
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    #2;
    chk("rst_accepts", 64'({out_ifu_arready, out_lsu_arready}), 64'd0);
    chk("rst_arvalid", 64'(out_arvalid), 64'd0);
    chk("rst_rready", 64'(out_rready), 64'd0);
    chk("rst_rvalids", 64'({out_ifu_rvalid, out_lsu_rvalid, out_rd_err}), 64'd0);
    chk("rst_fields", 64'({out_araddr, out_arlen, out_arsize, out_arburst, out_arid}), 64'd0);
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    tick(); tick();
    reset = 1'b0;

    do_txn(0, 0, 32'h0, 8'd0, 1, 32'h8000_0002, 8'h03, 0, -1, -1, 32'h1234);
    do_txn(1, 0, 32'h3000_0000, 8'd3, 0, 32'h0, 8'h00, 0, -1, -1, 32'hA0);

    order = '0;
    for (int i = 0; i < 5; i++) begin
      do_txn(1, 0, 32'h3000_0040, 8'd1, 1, 32'h8000_0010 + 32'(i * 4), 8'h0f, 0, -1, -1, 32'h100);
      order = {order[3:0], obs_win_ifu};
    end
    chk("starve_order", 64'(order), 64'b00001);
    do_txn(1, 1, 32'h3000_0080, 8'd0, 1, 32'h0, 8'h0f, 0, -1, -1, 32'h200);
    chk("lock_wins", 64'(obs_win_ifu), 64'd1);

    do_txn(1, 0, 32'h3000_0100, 8'd3, 0, 32'h0, 8'h00, 1, 1, -1, 32'h300);
    do_txn(0, 0, 32'h0, 8'd0, 1, 32'h8000_0020, 8'hff, 0, -1, -1, 32'h400);
    do_txn(0, 0, 32'h0, 8'd0, 1, 32'h8000_0030, 8'h01, 5, -1, 0, 32'h500);
    do_txn(1, 0, 32'h3000_0200, 8'd1, 0, 32'h0, 8'h00, 0, 1, -1, 32'h600);
    do_txn(1, 0, 32'h3000_0300, 8'd2, 0, 32'h0, 8'h00, 0, 0, 1, 32'h700);

    for (int i = 0; i < 24; i++) begin
      logic iv, lv;
      int   fa, ea;
      iv = 1'($urandom_range(0, 1));
      lv = 1'($urandom_range(0, 1));
      if (!iv && !lv && !ifu_arvalid) lv = 1'b1;
      fa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      ea = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_txn(iv | ifu_arvalid, 1'($urandom_range(0, 5) == 0), $urandom & 32'hFFFF_FFFC,
             8'($urandom_range(0, 3)), lv | lsu_arvalid, $urandom,
             strbs[$urandom_range(0, 4)], int'($urandom_range(0, 2)), fa, ea, $urandom);
    end

    // Reset in the middle of an LSU data phase with IFU waiting.
    tick();
    ifu_arvalid = 1'b1; ifu_lock = 1'b0; ifu_araddr = 32'h3000_0400; ifu_arlen = 8'd3;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0040; lsu_rstrb = 8'h0f;
    #2;
    chk("pre_rst_grant", 64'(out_ifu_arready), 64'(pick_ifu(1'b1, 1'b0, 1'b1, starve_m)));
    tick();
    if (out_ifu_arready === 1'b0) lsu_arvalid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_0000; rresp = 2'b10; rlast = 1'b0;
    #2;
    chk("pre_rst_rready", 64'(out_rready), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_rready", 64'(out_rready), 64'd0);
    chk("async_rst_rvalids", 64'({out_ifu_rvalid, out_lsu_rvalid, out_rd_err}), 64'd0);
    chk("async_rst_accepts", 64'({out_ifu_arready, out_lsu_arready}), 64'd0);
    chk("async_rst_arvalid", 64'(out_arvalid), 64'd0);
    chk("async_rst_fields", 64'({out_araddr, out_arlen, out_arsize, out_arburst, out_arid}), 64'd0);
    starve_m = 0;
    rvalid = 1'b0; rresp = 2'b00; ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    tick(); tick();
    reset = 1'b0;

    order = '0;
    for (int i = 0; i < 5; i++) begin
      do_txn(1, 0, 32'h3000_0500, 8'd0, 1, 32'h8000_0050 + 32'(i * 4), 8'h03, 0, -1, -1, 32'h800);
      order = {order[3:0], obs_win_ifu};
    end
    chk("post_rst_order", 64'(order), 64'b00001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
